// File: rtl/ne16_mbist_pkg.sv
// Shared types and the March C- element table for the ne16 accumulator memory-BIST engine.
package ne16_mbist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;

  typedef enum logic {OP_R, OP_W} op_e;

  typedef enum logic [1:0] {
    PAT_SOLID   = 2'b00,
    PAT_CHECKER = 2'b01,
    PAT_ADDR    = 2'b10,
    PAT_RSVD    = 2'b11
  } pattern_e;

  // One march element: address direction, up to two ops per address, and the data value
  // (0 = background, 1 = inverted background) each op writes or expects.
  typedef struct packed {
    logic       down;
    logic [1:0] n_ops;
    op_e        op0;
    logic       val0;
    op_e        op1;
    logic       val1;
  } march_step_t;

  localparam march_step_t MARCH_TBL [0:5] = '{
    '{1'b0, 2'd1, OP_W, 1'b0, OP_R, 1'b0},  // M0 up(w0)
    '{1'b0, 2'd2, OP_R, 1'b0, OP_W, 1'b1},  // M1 up(r0,w1)
    '{1'b0, 2'd2, OP_R, 1'b1, OP_W, 1'b0},  // M2 up(r1,w0)
    '{1'b1, 2'd2, OP_R, 1'b0, OP_W, 1'b1},  // M3 down(r0,w1)
    '{1'b1, 2'd2, OP_R, 1'b1, OP_W, 1'b0},  // M4 down(r1,w0)
    '{1'b0, 2'd1, OP_R, 1'b0, OP_R, 1'b0}   // M5 up(r0)
  };

endpackage

// File: rtl/ne16_mbist_cmp.sv
// Read-data compare path: delays expected word/address by the read latency, compares every
// bank, and keeps the fail mask, first-fail location and a saturating error count.
module ne16_mbist_cmp #(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_BANKS     = 4,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16,
  parameter int BANK_W        = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clr_i,
  input  logic                            flush_i,
  input  logic                            rd_vld_i,
  input  logic [DATA_WIDTH-1:0]           exp_i,
  input  logic [ADDR_WIDTH-1:0]           addr_i,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] q_i,
  output logic [NUM_BANKS-1:0]            fail_bank_o,
  output logic [ADDR_WIDTH-1:0]           first_fail_addr_o,
  output logic [BANK_W-1:0]               first_fail_bank_o,
  output logic [ERR_CNT_WIDTH-1:0]        err_cnt_o
);

  localparam int STAGES = RD_LATENCY - 1;

  logic [STAGES:0]         vld_pipe;
  logic [DATA_WIDTH-1:0]   exp_pipe  [STAGES:0];
  logic [ADDR_WIDTH-1:0]   addr_pipe [STAGES:0];
  logic [NUM_BANKS-1:0]    mis;
  logic [BANK_W-1:0]       low_bank;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || flush_i) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_vld_i;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    exp_pipe[0]  <= exp_i;
    addr_pipe[0] <= addr_i;
    for (int i = 1; i <= STAGES; i++) begin
      exp_pipe[i]  <= exp_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : gen_bank
    assign mis[b] = vld_pipe[STAGES] &&
                    (q_i[b*DATA_WIDTH +: DATA_WIDTH] != exp_pipe[STAGES]);
  end

  always_comb begin
    low_bank = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (mis[b]) low_bank = BANK_W'(b);
    end
  end

  // An empty fail mask marks that no mismatch has been seen yet in this run.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      fail_bank_o       <= '0;
      first_fail_addr_o <= '0;
      first_fail_bank_o <= '0;
      err_cnt_o         <= '0;
    end else if (!flush_i && (|mis)) begin
      fail_bank_o <= fail_bank_o | mis;
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_WIDTH'(1);
      if (fail_bank_o == '0) begin
        first_fail_addr_o <= addr_pipe[STAGES];
        first_fail_bank_o <= low_bank;
      end
    end
  end

endmodule

// File: rtl/ne16_accumulator_mbist_ctrl.sv
// March C- BIST controller for the ne16 accumulator SCM banks: sequences the BIST port,
// generates data backgrounds, and hands reads to the compare path.
module ne16_accumulator_mbist_ctrl
  import ne16_mbist_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_WORDS     = 2**ADDR_WIDTH,
  parameter int NUM_BANKS     = 4,
  parameter int RD_LATENCY    = 1,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              start_i,
  input  logic                                              abort_i,
  input  logic [1:0]                                        pattern_i,
  output logic                                              busy_o,
  output logic                                              done_o,
  output logic                                              pass_o,
  output logic                                              bist_o,
  output logic                                              csn_t_o,
  output logic                                              wen_t_o,
  output logic [ADDR_WIDTH-1:0]                             a_t_o,
  output logic [DATA_WIDTH-1:0]                             d_t_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]                   q_t_i,
  output logic [NUM_BANKS-1:0]                              fail_bank_o,
  output logic [ADDR_WIDTH-1:0]                             first_fail_addr_o,
  output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] first_fail_bank_o,
  output logic [ERR_CNT_WIDTH-1:0]                          err_cnt_o
);

  localparam int BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int DRAIN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_STEP  = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam logic [DRAIN_W-1:0]    DRAIN_LAST = DRAIN_W'(RD_LATENCY - 1);

  state_e                state, state_nxt;
  march_elem_e           elem;
  march_step_t           ms;
  pattern_e              pat_q;
  logic [ADDR_WIDTH-1:0] step;
  logic                  op_idx;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  start_acc, addr_done, seq_done;
  op_e                   cur_op;
  logic                  cur_val;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_word;

  function automatic logic [DATA_WIDTH-1:0] bg_word(pattern_e p, logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] w;
    w = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      case (p)
        PAT_CHECKER: w[i] = (i % 2 == 0) ^ a[0];
        PAT_ADDR:    w[i] = a[i % ADDR_WIDTH];
        default:     w[i] = 1'b0;
      endcase
    end
    return w;
  endfunction

  assign ms        = MARCH_TBL[elem];
  assign addr_done = (({1'b0, op_idx} + 2'd1) == ms.n_ops);
  assign seq_done  = addr_done && (step == LAST_STEP) && (elem == M5);

  always_comb begin
    cur_op   = op_idx ? ms.op1  : ms.op0;
    cur_val  = op_idx ? ms.val1 : ms.val0;
    cur_addr = ms.down ? (LAST_STEP - step) : step;
    cur_word = bg_word(pat_q, cur_addr) ^ {DATA_WIDTH{cur_val}};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start_i) begin
        state_nxt = ST_RUN;
        start_acc = 1'b1;
      end
      ST_RUN:   if (seq_done) state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (abort_i) begin
      state_nxt = ST_IDLE;
      start_acc = 1'b0;
    end
  end

  // Step counts positions within an element; direction is applied when forming the address.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_acc) begin
      elem      <= M0;
      step      <= '0;
      op_idx    <= 1'b0;
      drain_cnt <= '0;
      pat_q     <= rst_i ? PAT_SOLID : pattern_e'(pattern_i);
    end else if (state == ST_RUN) begin
      drain_cnt <= '0;
      if (addr_done) begin
        op_idx <= 1'b0;
        if (step == LAST_STEP) begin
          step <= '0;
          if (elem != M5) elem <= march_elem_e'(elem + 3'd1);
        end else begin
          step <= step + ADDR_WIDTH'(1);
        end
      end else begin
        op_idx <= 1'b1;
      end
    end else if (state == ST_DRAIN) begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  always_comb begin
    busy_o  = (state == ST_RUN) || (state == ST_DRAIN);
    done_o  = (state == ST_DONE);
    bist_o  = (state == ST_RUN) || (state == ST_DRAIN);
    csn_t_o = 1'b1;
    wen_t_o = 1'b1;
    a_t_o   = '0;
    d_t_o   = '0;
    if (state == ST_RUN) begin
      csn_t_o = 1'b0;
      wen_t_o = (cur_op != OP_W);
      a_t_o   = cur_addr;
      d_t_o   = cur_word;
    end
  end

  assign pass_o = done_o && (fail_bank_o == '0);

  ne16_mbist_cmp #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_BANKS    (NUM_BANKS),
    .RD_LATENCY   (RD_LATENCY),
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH),
    .BANK_W       (BANK_W)
  ) u_cmp (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .clr_i            (start_acc),
    .flush_i          (abort_i),
    .rd_vld_i         ((state == ST_RUN) && (cur_op == OP_R)),
    .exp_i            (cur_word),
    .addr_i           (cur_addr),
    .q_i              (q_t_i),
    .fail_bank_o      (fail_bank_o),
    .first_fail_addr_o(first_fail_addr_o),
    .first_fail_bank_o(first_fail_bank_o),
    .err_cnt_o        (err_cnt_o)
  );

endmodule

// File: tb/tb_ne16_accumulator_mbist_ctrl.sv
// Directed bench: two controllers share stimulus; A sees an optional single stuck bit,
// B (2-bit error counter) sees bank 0 bit 0 stuck-at-0 everywhere.
module tb_ne16_accumulator_mbist_ctrl;
  localparam int AW = 5, DW = 32, NB = 4, N = 32;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [1:0] pattern = 2'b00;
  logic fault_en = 1'b0;
  int   checks = 0, passed = 0, cyc = 0;

  logic busy_a, done_a, pass_a, bist_a, csn_a, wen_a;
  logic [AW-1:0] a_a, ffa_a;
  logic [DW-1:0] d_a;
  logic [NB*DW-1:0] q_a;
  logic [NB-1:0] fb_a;
  logic [1:0] ffb_a;
  logic [15:0] err_a;

  logic busy_b, done_b, pass_b, bist_b, csn_b, wen_b;
  logic [AW-1:0] a_b, ffa_b;
  logic [DW-1:0] d_b;
  logic [NB*DW-1:0] q_b;
  logic [NB-1:0] fb_b;
  logic [1:0] ffb_b;
  logic [1:0] err_b;

  logic [DW-1:0] mem_a [NB][N];
  logic [DW-1:0] mem_b [NB][N];

  always #5 clk = ~clk;

  ne16_accumulator_mbist_ctrl dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pattern_i(pattern),
    .busy_o(busy_a), .done_o(done_a), .pass_o(pass_a), .bist_o(bist_a),
    .csn_t_o(csn_a), .wen_t_o(wen_a), .a_t_o(a_a), .d_t_o(d_a), .q_t_i(q_a),
    .fail_bank_o(fb_a), .first_fail_addr_o(ffa_a), .first_fail_bank_o(ffb_a), .err_cnt_o(err_a));

  ne16_accumulator_mbist_ctrl #(.ERR_CNT_WIDTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .pattern_i(pattern),
    .busy_o(busy_b), .done_o(done_b), .pass_o(pass_b), .bist_o(bist_b),
    .csn_t_o(csn_b), .wen_t_o(wen_b), .a_t_o(a_b), .d_t_o(d_b), .q_t_i(q_b),
    .fail_bank_o(fb_b), .first_fail_addr_o(ffa_b), .first_fail_bank_o(ffb_b), .err_cnt_o(err_b));

  // One-cycle-latency SCM models with read-side fault injection.
  always @(posedge clk) begin
    if (!csn_a) for (int b = 0; b < NB; b++) begin
      if (!wen_a) mem_a[b][a_a] <= d_a;
      else q_a[b*DW +: DW] <= mem_a[b][a_a] |
                              ((fault_en && b == 2 && a_a == 5'd7) ? 32'h0000_0008 : 32'h0);
    end
    if (!csn_b) for (int b = 0; b < NB; b++) begin
      if (!wen_b) mem_b[b][a_b] <= d_b;
      else q_b[b*DW +: DW] <= mem_b[b][a_b] & ((b == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
    end
  end

  task automatic step();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_start(input logic [1:0] p);
    pattern = p; start = 1'b1; cyc = 0;
    step();
    start = 1'b0; pattern = 2'b00;
  endtask

  task automatic wait_done();
    while (!done_a && cyc < 600) step();
    checks++;
    if (cyc !== 322) $display("FAIL done_cycle: got %0d want 322", cyc); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    checks++;
    if ({busy_a, done_a, pass_a, bist_a} !== 4'b0000)
      $display("FAIL reset_status: got %b want 0000", {busy_a, done_a, pass_a, bist_a});
    else passed++;
    checks++;
    if ({csn_a, wen_a} !== 2'b11) $display("FAIL reset_ctl: got %b want 11", {csn_a, wen_a});
    else passed++;
    checks++;
    if ({a_a, d_a} !== '0) $display("FAIL reset_ad: got %0h want 0", {a_a, d_a}); else passed++;
    checks++;
    if ({fb_a, ffa_a, ffb_a, err_a} !== '0)
      $display("FAIL reset_results: got %0h want 0", {fb_a, ffa_a, ffb_a, err_a});
    else passed++;
    rst = 1'b0; step();
    checks++;
    if ({busy_a, done_a} !== 2'b00) $display("FAIL idle_after_reset: got %b want 00", {busy_a, done_a});
    else passed++;
  endtask

  task automatic test_clean_run();
    int nops;
    fault_en = 1'b0;
    run_start(2'b00);
    checks++;
    if ({busy_a, bist_a, csn_a, wen_a, a_a, d_a} !== {4'b1100, 5'd0, 32'h0})
      $display("FAIL first_op: got %0h want %0h", {busy_a, bist_a, csn_a, wen_a, a_a, d_a},
               {4'b1100, 5'd0, 32'h0});
    else passed++;
    nops = 1;
    while (!done_a && cyc < 600) begin
      step();
      if (!csn_a) nops++;
      if (cyc == 321) begin
        checks++;
        if ({bist_a, csn_a, busy_a, done_a} !== 4'b1110)
          $display("FAIL drain_levels: got %b want 1110", {bist_a, csn_a, busy_a, done_a});
        else passed++;
      end
    end
    checks++;
    if (cyc !== 322) $display("FAIL done_cycle: got %0d want 322", cyc); else passed++;
    checks++;
    if (nops !== 320) $display("FAIL op_count: got %0d want 320", nops); else passed++;
    checks++;
    if ({pass_a, busy_a, bist_a, fb_a, err_a} !== {3'b100, 4'b0, 16'h0})
      $display("FAIL clean_result: got %0h want %0h", {pass_a, busy_a, bist_a, fb_a, err_a},
               {3'b100, 4'b0, 16'h0});
    else passed++;
  endtask

  task automatic test_stuck_bit();
    fault_en = 1'b1;
    run_start(2'b00);
    wait_done();
    checks++;
    if (fb_a !== 4'b0100) $display("FAIL stuck_mask: got %b want 0100", fb_a); else passed++;
    checks++;
    if ({ffa_a, ffb_a} !== {5'd7, 2'd2})
      $display("FAIL stuck_first: got addr %0d bank %0d want addr 7 bank 2", ffa_a, ffb_a);
    else passed++;
    checks++;
    if (err_a !== 16'd3) $display("FAIL stuck_err: got %0d want 3", err_a); else passed++;
    checks++;
    if (pass_a !== 1'b0) $display("FAIL stuck_pass: got %b want 0", pass_a); else passed++;
    fault_en = 1'b0;
  endtask

  task automatic test_checker_m3();
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int bad_a, bad_d;
    bad_a = 0; bad_d = 0;
    run_start(2'b01);
    while (cyc < 5*N) step();
    for (int k = 0; k < 2*N; k++) begin
      step();
      ea = AW'(N - 1 - k/2);
      ed = ea[0] ? 32'h5555_5555 : 32'hAAAA_AAAA;
      if (a_a !== ea) bad_a++;
      if ((k % 2 == 1) && (wen_a !== 1'b0 || d_a !== ed)) bad_d++;
      if ((k % 2 == 0) && (wen_a !== 1'b1)) bad_d++;
    end
    checks++;
    if (bad_a !== 0) $display("FAIL m3_addr_trace: got %0d bad cycles want 0", bad_a); else passed++;
    checks++;
    if (bad_d !== 0) $display("FAIL m3_write_data: got %0d bad cycles want 0", bad_d); else passed++;
    wait_done();
    checks++;
    if (pass_a !== 1'b1) $display("FAIL checker_pass: got %b want 1", pass_a); else passed++;
  endtask

  task automatic test_patterns();
    run_start(2'b10);
    step();
    checks++;
    if (d_a !== 32'h4210_8421) $display("FAIL addr_bg_a1: got %h want 42108421", d_a); else passed++;
    step();
    checks++;
    if (d_a !== 32'h8421_0842) $display("FAIL addr_bg_a2: got %h want 84210842", d_a); else passed++;
    wait_done();
    checks++;
    if (pass_a !== 1'b1) $display("FAIL addr_bg_pass: got %b want 1", pass_a); else passed++;
    run_start(2'b11);
    while (cyc < N + 2) step();
    checks++;
    if ({wen_a, a_a, d_a} !== {1'b0, 5'd0, 32'hFFFF_FFFF})
      $display("FAIL pat11_w1: got %0h want %0h", {wen_a, a_a, d_a}, {1'b0, 5'd0, 32'hFFFF_FFFF});
    else passed++;
    wait_done();
    checks++;
    if (pass_a !== 1'b1) $display("FAIL pat11_pass: got %b want 1", pass_a); else passed++;
  endtask

  task automatic test_abort();
    run_start(2'b00);
    while (cyc < 100) step();
    abort = 1'b1; step(); abort = 1'b0;
    checks++;
    if ({bist_a, busy_a, done_a, csn_a} !== 4'b0001)
      $display("FAIL abort_levels: got %b want 0001", {bist_a, busy_a, done_a, csn_a});
    else passed++;
    run_start(2'b00);
    while (cyc < 50) step();
    start = 1'b1; step(); start = 1'b0;
    checks++;
    if (busy_a !== 1'b1) $display("FAIL start_in_run: got busy %b want 1", busy_a); else passed++;
    wait_done();
    checks++;
    if ({pass_a, err_a} !== {1'b1, 16'h0})
      $display("FAIL rerun_result: got %0h want %0h", {pass_a, err_a}, {1'b1, 16'h0});
    else passed++;
  endtask

  task automatic test_reset_mid();
    fault_en = 1'b1;
    run_start(2'b00);
    while (cyc < 150) step();
    rst = 1'b1; step(); rst = 1'b0;
    checks++;
    if ({busy_a, done_a, bist_a, csn_a, wen_a, a_a} !== {5'b00011, 5'd0})
      $display("FAIL midreset_ctl: got %0h want %0h", {busy_a, done_a, bist_a, csn_a, wen_a, a_a},
               {5'b00011, 5'd0});
    else passed++;
    checks++;
    if ({fb_a, err_a} !== '0) $display("FAIL midreset_results: got %0h want 0", {fb_a, err_a});
    else passed++;
    while (cyc < 160) step();
    run_start(2'b00);
    wait_done();
    checks++;
    if ({fb_a, err_a} !== {4'b0100, 16'd3})
      $display("FAIL fresh_results: got %0h want %0h", {fb_a, err_a}, {4'b0100, 16'd3});
    else passed++;
    fault_en = 1'b0;
  endtask

  task automatic test_saturate();
    run_start(2'b00);
    wait_done();
    checks++;
    if (err_b !== 2'd3) $display("FAIL sat_err: got %0d want 3", err_b); else passed++;
    checks++;
    if ({fb_b, ffa_b, ffb_b} !== {4'b0001, 5'd0, 2'd0})
      $display("FAIL sat_first: got %0h want %0h", {fb_b, ffa_b, ffb_b}, {4'b0001, 5'd0, 2'd0});
    else passed++;
    checks++;
    if ({done_b, pass_b} !== 2'b10) $display("FAIL sat_pass: got %b want 10", {done_b, pass_b});
    else passed++;
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_stuck_bit();
    test_checker_m3();
    test_patterns();
    test_abort();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
